// File: rtl/vedic_mac_pkg.sv
// Shared types, default widths and the accumulator add helper for the Vedic MAC stage.
package vedic_mac_pkg;

    localparam int unsigned PROD_W = 64;
    localparam int unsigned ACC_W  = 72;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        StAccum,
        StHold
    } state_e;

    // Returns {carry, sum} of acc + zero-extended prod; the caller decides wrap vs clamp.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]  acc,
                                               input logic [PROD_W-1:0] prod);
        return {1'b0, acc} + {{(ACC_W - PROD_W + 1){1'b0}}, prod};
    endfunction

endpackage

// File: rtl/vedic_mac_accumulator_if.sv
// Product-in / result-out streaming bus of the Vedic MAC accumulator.
// master: upstream multiplier plus result consumer; slave: the accumulator.
interface vedic_mac_accumulator_if #(
    parameter int unsigned PROD_W = vedic_mac_pkg::PROD_W,
    parameter int unsigned ACC_W  = vedic_mac_pkg::ACC_W,
    parameter int unsigned CNT_W  = vedic_mac_pkg::CNT_W
);
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod;
    logic              prod_last;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [CNT_W-1:0]  res_count;
    logic              res_ovf;

    modport master (
        output prod_valid, prod, prod_last, res_ready,
        input  prod_ready, res_valid, res_data, res_count, res_ovf
    );

    modport slave (
        input  prod_valid, prod, prod_last, res_ready,
        output prod_ready, res_valid, res_data, res_count, res_ovf
    );
endinterface

// File: rtl/vedic_mac_result_reg.sv
// Frame result holding register: loads on a last beat, holds until consumed.
module vedic_mac_result_reg #(
    parameter int unsigned ACC_W = vedic_mac_pkg::ACC_W,
    parameter int unsigned CNT_W = vedic_mac_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [ACC_W-1:0] data_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             ovf_i,
    input  logic             res_ready_i,
    output logic             res_valid_o,
    output logic [ACC_W-1:0] res_data_o,
    output logic [CNT_W-1:0] res_count_o,
    output logic             res_ovf_o,
    output logic             accept_o
);
    logic             valid_q, valid_d;
    logic [ACC_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    assign accept_o = valid_q & res_ready_i;

    // Load wins over drop so a last beat in the handshake cycle keeps valid high.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            count_d = count_i;
            ovf_d   = ovf_i;
        end else if (accept_o) begin
            valid_d = 1'b0;
        end
    end

    // Result state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign res_valid_o = valid_q;
    assign res_data_o  = data_q;
    assign res_count_o = count_q;
    assign res_ovf_o   = ovf_q;
endmodule

// File: rtl/vedic_mac_accumulator.sv
// Streaming MAC stage behind the 32x32 Vedic multiplier: sums products per frame and
// returns {sum, beat count, overflow} over a valid/ready result port.
// Build option: VEDIC_MAC_SATURATE_EN clamps the accumulator on carry-out instead of wrapping.
// PROD_W/ACC_W must match the package defaults used by sat_add.
module vedic_mac_accumulator #(
    parameter int unsigned PROD_W = vedic_mac_pkg::PROD_W,
    parameter int unsigned ACC_W  = vedic_mac_pkg::ACC_W,
    parameter int unsigned CNT_W  = vedic_mac_pkg::CNT_W
) (
    input logic                    clk,
    input logic                    rst,
    vedic_mac_accumulator_if.slave bus
);
    import vedic_mac_pkg::*;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum, add_sum;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sum;
    logic             ovf_q, ovf_d, ovf_sum;
    logic             add_carry, cnt_max;
    logic             beat, frame_end, accept;

    // In HOLD the consumer's ready passes straight through, so no bubble between frames.
    assign bus.prod_ready = (state_q == StAccum) | bus.res_ready;
    assign beat           = bus.prod_valid & bus.prod_ready;
    assign frame_end      = beat & bus.prod_last;

    // Accumulator datapath: next sum/count/overflow and the per-beat update.
    always_comb begin
        {add_carry, add_sum} = sat_add(acc_q, bus.prod);
        acc_sum = add_sum;
`ifdef VEDIC_MAC_SATURATE_EN
        if (add_carry) begin
            acc_sum = '1;
        end
`endif
        cnt_max = &cnt_q;
        cnt_sum = cnt_max ? cnt_q : cnt_q + CNT_W'(1);
        ovf_sum = ovf_q | add_carry | cnt_max;

        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (beat) begin
            if (bus.prod_last) begin
                // Frame closes: totals go to the result register, next frame starts clean.
                acc_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_sum;
                ovf_d = ovf_sum;
            end
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: if (frame_end) state_d = StHold;
            StHold:  if (accept && !frame_end) state_d = StAccum;
            default: state_d = StAccum;
        endcase
    end

    // State and accumulator registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccum;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    vedic_mac_result_reg #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_result_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (frame_end),
        .data_i      (acc_sum),
        .count_i     (cnt_sum),
        .ovf_i       (ovf_sum),
        .res_ready_i (bus.res_ready),
        .res_valid_o (bus.res_valid),
        .res_data_o  (bus.res_data),
        .res_count_o (bus.res_count),
        .res_ovf_o   (bus.res_ovf),
        .accept_o    (accept)
    );
endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// Directed bench for vedic_mac_accumulator: a table of per-cycle steps plus long-frame
// overflow sequences. Honours VEDIC_MAC_SATURATE_EN for the overflowing-frame sum.
module tb_vedic_mac_accumulator;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    vedic_mac_accumulator_if bus ();

    vedic_mac_accumulator u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          pv;
        logic [63:0] prod;
        bit          last;
        bit          rr;
        bit          chk_pr;
        bit          pr;
        bit          rv;
        bit          chk_res;
        logic [71:0] data;
        logic [7:0]  cnt;
        bit          ovf;
    } step_t;

    step_t steps[$];

    function automatic step_t mk(bit r, bit pv, logic [63:0] prod, bit last, bit rr,
                                 bit chk_pr, bit pr, bit rv, bit chk_res,
                                 logic [71:0] data, logic [7:0] cnt, bit ovf);
        step_t s;
        s.rst = r; s.pv = pv; s.prod = prod; s.last = last; s.rr = rr;
        s.chk_pr = chk_pr; s.pr = pr; s.rv = rv; s.chk_res = chk_res;
        s.data = data; s.cnt = cnt; s.ovf = ovf;
        return s;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit pv, input logic [63:0] prod, input bit last,
                         input bit rr);
        rst            = r;
        bus.prod_valid = pv;
        bus.prod       = prod;
        bus.prod_last  = last;
        bus.res_ready  = rr;
    endtask

    // Streams n beats of value v (last on the n-th) and checks the resulting frame.
    task automatic run_frame(input string name, input int n, input logic [63:0] v,
                             input logic [71:0] exp_data, input logic [7:0] exp_cnt,
                             input bit exp_ovf);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, v, (i == n - 1), 1'b1);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        check({name, "_rv"}, {71'd0, bus.res_valid}, 72'd1);
        check({name, "_data"}, bus.res_data, exp_data);
        check({name, "_cnt"}, {64'd0, bus.res_count}, {64'd0, exp_cnt});
        check({name, "_ovf"}, {71'd0, bus.res_ovf}, {71'd0, exp_ovf});
        // Consume the result so the next frame starts from ACCUM.
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_drain"}, {71'd0, bus.res_valid}, 72'd0);
    endtask

    localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        logic [71:0] exp257;
        checks   = 0;
        failures = 0;
        drive(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);

        //                 rst pv prod  last rr cpr pr rv cres data cnt ovf
        steps.push_back(mk(1, 0, 0,     0, 1, 0, 0, 0, 1, 0,  0, 0)); // reset values
        steps.push_back(mk(0, 0, 0,     0, 1, 1, 1, 0, 0, 0,  0, 0));
        // 5 + 7 + 11
        steps.push_back(mk(0, 1, 5,     0, 1, 1, 1, 0, 0, 0,  0, 0));
        steps.push_back(mk(0, 1, 7,     0, 1, 1, 1, 0, 0, 0,  0, 0));
        steps.push_back(mk(0, 1, 11,    1, 1, 1, 1, 1, 1, 23, 3, 0));
        steps.push_back(mk(0, 0, 0,     0, 1, 1, 1, 0, 0, 0,  0, 0));
        // single full-scale beat
        steps.push_back(mk(0, 1, Ones,  1, 1, 1, 1, 1, 1, {8'h00, Ones}, 1, 0));
        // consumer stalls 5 cycles, upstream offers a beat that must not be taken
        for (int i = 0; i < 5; i++)
            steps.push_back(mk(0, 1, 100, 0, 0, 1, 0, 1, 1, {8'h00, Ones}, 1, 0));
        // ready returns together with a last beat: result reloads, valid stays high
        steps.push_back(mk(0, 1, 9,     1, 1, 1, 1, 1, 1, 9,  1, 0));
        steps.push_back(mk(0, 0, 0,     0, 1, 1, 1, 0, 0, 0,  0, 0));
        // reset mid-frame discards 100 + 200
        steps.push_back(mk(0, 1, 100,   0, 1, 1, 1, 0, 0, 0,  0, 0));
        steps.push_back(mk(0, 1, 200,   0, 1, 1, 1, 0, 0, 0,  0, 0));
        steps.push_back(mk(1, 0, 0,     0, 1, 1, 1, 0, 1, 0,  0, 0));
        steps.push_back(mk(0, 1, 3,     0, 1, 1, 1, 0, 0, 0,  0, 0));
        steps.push_back(mk(0, 1, 4,     1, 1, 1, 1, 1, 1, 7,  2, 0));
        // reset while a result is held and stalled
        steps.push_back(mk(1, 0, 0,     0, 0, 1, 0, 0, 1, 0,  0, 0));
        // back-to-back single-beat frames
        steps.push_back(mk(0, 1, 10,    1, 1, 1, 1, 1, 1, 10, 1, 0));
        steps.push_back(mk(0, 1, 20,    1, 1, 1, 1, 1, 1, 20, 1, 0));
        steps.push_back(mk(0, 1, 30,    1, 1, 1, 1, 1, 1, 30, 1, 0));
        steps.push_back(mk(0, 0, 0,     0, 1, 1, 1, 0, 0, 0,  0, 0));
        // handshake in HOLD with a non-last beat opens a new frame
        steps.push_back(mk(0, 1, 1,     1, 1, 1, 1, 1, 1, 1,  1, 0));
        steps.push_back(mk(0, 1, 2,     0, 1, 1, 1, 0, 0, 0,  0, 0));
        steps.push_back(mk(0, 1, 3,     1, 1, 1, 1, 1, 1, 5,  2, 0));
        steps.push_back(mk(0, 0, 0,     0, 1, 1, 1, 0, 0, 0,  0, 0));

        for (int i = 0; i < steps.size(); i++) begin
            drive(steps[i].rst, steps[i].pv, steps[i].prod, steps[i].last, steps[i].rr);
            #1;
            if (steps[i].chk_pr)
                check($sformatf("s%0d_prod_ready", i), {71'd0, bus.prod_ready},
                      {71'd0, steps[i].pr});
            @(posedge clk);
            #1;
            check($sformatf("s%0d_res_valid", i), {71'd0, bus.res_valid}, {71'd0, steps[i].rv});
            if (steps[i].chk_res) begin
                check($sformatf("s%0d_res_data", i), bus.res_data, steps[i].data);
                check($sformatf("s%0d_res_count", i), {64'd0, bus.res_count},
                      {64'd0, steps[i].cnt});
                check($sformatf("s%0d_res_ovf", i), {71'd0, bus.res_ovf}, {71'd0, steps[i].ovf});
            end
        end

        // 255 full-scale beats: count reaches max, no overflow yet
        run_frame("f255_ones", 255, Ones, 72'hFE_FFFF_FFFF_FFFF_FF01, 8'd255, 1'b0);
        // 256 zero beats: overflow from the count alone
        run_frame("f256_zero", 256, 64'd0, 72'd0, 8'd255, 1'b1);
        // 257 full-scale beats: accumulator carries out on the 257th
`ifdef VEDIC_MAC_SATURATE_EN
        exp257 = {72{1'b1}};
`else
        exp257 = 72'h00_FFFF_FFFF_FFFF_FEFF;
`endif
        run_frame("f257_ones", 257, Ones, exp257, 8'd255, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
